// File: rtl/wb_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg: definitions shared by the writeback port arbiter and its parts.
//   XLEN         - data width of every requester and of the write port
//   wb_req_sel_e - selects the requester that owns the write port this cycle
//   wb_req_t     - one requester's view: valid, destination rd, result data
// ---------------------------------------------------------------------------
package wb_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      REQ_PIPE = 2'd0,
      REQ_LD   = 2'd1,
      REQ_MD   = 2'd2,
      REQ_NONE = 2'd3
   } wb_req_sel_e;

   typedef struct packed {
      logic            valid;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_if: the three requester handshakes plus the register-file
// write port, bundled for the arbiter.
//
// Handshake: a requester raises *_valid with *_rd / *_data and holds all three
// stable until the cycle in which *_ready is also high; that cycle is the
// transfer. *_ready is never high while the matching *_valid is low, and at
// most one *_ready is high in any cycle.
//
//   modport slave  - arbiter side: takes requests, drives ready and wb_*
//   modport master - producer/writeback side: the mirror image
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if #(
   parameter int XLEN = wb_pkg::XLEN
);
   logic            pipe_valid;
   logic [4:0]      pipe_rd;
   logic [XLEN-1:0] pipe_data;
   logic            pipe_ready;

   logic            ld_valid;
   logic [4:0]      ld_rd;
   logic [XLEN-1:0] ld_data;
   logic            ld_ready;

   logic            md_valid;
   logic [4:0]      md_rd;
   logic [XLEN-1:0] md_data;
   logic            md_ready;

   logic            wb_we;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;

   modport slave (
      input  pipe_valid, pipe_rd, pipe_data,
      input  ld_valid, ld_rd, ld_data,
      input  md_valid, md_rd, md_data,
      output pipe_ready, ld_ready, md_ready,
      output wb_we, wb_rd, wb_data
   );

   modport master (
      output pipe_valid, pipe_rd, pipe_data,
      output ld_valid, ld_rd, ld_data,
      output md_valid, md_rd, md_data,
      input  pipe_ready, ld_ready, md_ready,
      input  wb_we, wb_rd, wb_data
   );
endinterface

// File: rtl/wb_port_arbiter_starve_ctr.sv
// ---------------------------------------------------------------------------
// wb_starve_ctr: counts the cycles a request has been waiting without a grant.
//   clk, rst   - clock, synchronous active-high reset
//   valid_i    - the requester is presenting a request
//   grant_i    - the requester is accepted this cycle
//   starved_o  - count has reached STARVE_LIMIT (promote the requester)
// The count clears whenever the requester is idle or served, otherwise it
// climbs by one per cycle and saturates at STARVE_LIMIT.
// ---------------------------------------------------------------------------
module wb_starve_ctr #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic valid_i,
   input  logic grant_i,
   output logic starved_o
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!valid_i || grant_i) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign starved_o = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter: shares the single register-file write port between the
// main pipe, the load response path and the mul/div unit.
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - requester handshakes and registered write port (slave modport)
// Priority, highest first: starved load, starved mul/div, pipe, load, mul/div.
// A grant is written out one cycle later; rd==0 consumes the slot but does
// not assert wb_we. Without a grant wb_we drops and wb_rd/wb_data hold.
// ---------------------------------------------------------------------------
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   wb_port_arbiter_if.slave bus
);

   wb_req_t     pipe_req;
   wb_req_t     ld_req;
   wb_req_t     md_req;
   wb_req_sel_e sel;
   logic        ld_starved;
   logic        md_starved;

   logic            wb_we_q,   wb_we_d;
   logic [4:0]      wb_rd_q,   wb_rd_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;

   assign pipe_req = '{valid: bus.pipe_valid, rd: bus.pipe_rd, data: bus.pipe_data};
   assign ld_req   = '{valid: bus.ld_valid,   rd: bus.ld_rd,   data: bus.ld_data};
   assign md_req   = '{valid: bus.md_valid,   rd: bus.md_rd,   data: bus.md_data};

   wb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_ld_ctr (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (ld_req.valid),
      .grant_i   (sel == REQ_LD),
      .starved_o (ld_starved)
   );

   wb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_md_ctr (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (md_req.valid),
      .grant_i   (sel == REQ_MD),
      .starved_o (md_starved)
   );

   // Grant selection. The starved flags are also gated with valid so a stale
   // count can never hand out ready to an idle requester. Nothing is granted
   // in a reset cycle; requesters simply keep valid and are served afterwards.
   always_comb begin
      sel = REQ_NONE;
      if (!rst) begin
         if (ld_req.valid && ld_starved) begin
            sel = REQ_LD;
         end else if (md_req.valid && md_starved) begin
            sel = REQ_MD;
         end else if (pipe_req.valid) begin
            sel = REQ_PIPE;
         end else if (ld_req.valid) begin
            sel = REQ_LD;
         end else if (md_req.valid) begin
            sel = REQ_MD;
         end
      end
   end

   assign bus.pipe_ready = (sel == REQ_PIPE);
   assign bus.ld_ready   = (sel == REQ_LD);
   assign bus.md_ready   = (sel == REQ_MD);

   // Write-port next state: load the winner's rd/data, write only for rd!=0.
   always_comb begin
      wb_we_d   = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      case (sel)
         REQ_PIPE: begin
            wb_we_d   = |pipe_req.rd;
            wb_rd_d   = pipe_req.rd;
            wb_data_d = pipe_req.data;
         end
         REQ_LD: begin
            wb_we_d   = |ld_req.rd;
            wb_rd_d   = ld_req.rd;
            wb_data_d = ld_req.data;
         end
         REQ_MD: begin
            wb_we_d   = |md_req.rd;
            wb_rd_d   = md_req.rd;
            wb_data_d = md_req.data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_we_q   <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         wb_we_q   <= wb_we_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign bus.wb_we   = wb_we_q;
   assign bus.wb_rd   = wb_rd_q;
   assign bus.wb_data = wb_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter: directed bench for wb_port_arbiter (STARVE_LIMIT=4).
// Each step states which ready is expected; a granted request's {we,rd,data}
// is pushed to exp_q and compared against the write port one cycle later.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;
   import wb_pkg::*;

   localparam int W = 1 + 5 + XLEN;

   logic clk;
   logic rst;

   wb_port_arbiter_if ifc ();

   wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0]    exp_q[$];
   logic [4:0]      last_rd   = '0;
   logic [XLEN-1:0] last_data = '0;

   task automatic drive_pipe(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
      ifc.pipe_valid = v; ifc.pipe_rd = rd; ifc.pipe_data = d;
   endtask

   task automatic drive_ld(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
      ifc.ld_valid = v; ifc.ld_rd = rd; ifc.ld_data = d;
   endtask

   task automatic drive_md(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
      ifc.md_valid = v; ifc.md_rd = rd; ifc.md_data = d;
   endtask

   // One clock step. Called 1 time unit after a rising edge with inputs set.
   // exp_rdy is {pipe_ready, ld_ready, md_ready}.
   task automatic tick(input logic [2:0] exp_rdy, input string tag);
      logic [2:0]      obs_rdy;
      logic [4:0]      g_rd;
      logic [XLEN-1:0] g_data;
      logic [W-1:0]    exp_wb;
      logic [W-1:0]    obs_wb;
      #2;
      obs_rdy = {ifc.pipe_ready, ifc.ld_ready, ifc.md_ready};
      checks++;
      assert (obs_rdy === exp_rdy) else begin
         failures++;
         $error("FAIL %s ready observed=%b expected=%b", tag, obs_rdy, exp_rdy);
      end
      // expected write-port contents for the next cycle
      if (rst) begin
         last_rd = '0; last_data = '0;
         exp_q.push_back({1'b0, 5'd0, {XLEN{1'b0}}});
      end else if (exp_rdy != 3'b000) begin
         g_rd   = exp_rdy[2] ? ifc.pipe_rd   : exp_rdy[1] ? ifc.ld_rd   : ifc.md_rd;
         g_data = exp_rdy[2] ? ifc.pipe_data : exp_rdy[1] ? ifc.ld_data : ifc.md_data;
         last_rd = g_rd; last_data = g_data;
         exp_q.push_back({(g_rd != 5'd0), g_rd, g_data});
      end else begin
         exp_q.push_back({1'b0, last_rd, last_data});
      end
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         exp_wb = exp_q.pop_front();
         obs_wb = {ifc.wb_we, ifc.wb_rd, ifc.wb_data};
         checks++;
         assert (obs_wb === exp_wb) else begin
            failures++;
            $error("FAIL %s wb {we,rd,data} observed=%b/%0d/%h expected=%b/%0d/%h", tag,
                   obs_wb[W-1], obs_wb[W-2 -: 5], obs_wb[XLEN-1:0],
                   exp_wb[W-1], exp_wb[W-2 -: 5], exp_wb[XLEN-1:0]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      drive_pipe(1'b1, 5'd1, 32'h11);
      drive_ld  (1'b1, 5'd2, 32'h22);
      drive_md  (1'b1, 5'd3, 32'h33);
      @(posedge clk);
      #1;

      // reset held with all valids high: no ready, outputs zero
      tick(3'b000, "rst0");
      tick(3'b000, "rst1");
      rst = 1'b0;

      // priority: the same three requests are served pipe, ld, md
      tick(3'b100, "pri_pipe");
      drive_pipe(1'b0, 5'd0, 32'h0);
      tick(3'b010, "pri_ld");
      drive_ld(1'b0, 5'd0, 32'h0);
      tick(3'b001, "pri_md");
      drive_md(1'b0, 5'd0, 32'h0);
      tick(3'b000, "pri_idle");

      // single pipe request
      drive_pipe(1'b1, 5'd5, 32'h1234);
      tick(3'b100, "single");
      drive_pipe(1'b0, 5'd0, 32'h0);
      tick(3'b000, "single_idle");

      // mul/div starves behind a continuously busy pipe
      drive_md(1'b1, 5'd7, 32'hBEEF);
      for (int i = 0; i < 4; i++) begin
         drive_pipe(1'b1, 5'(10 + i), 32'(32'h100 + i));
         tick(3'b100, "starve_pipe");
      end
      drive_pipe(1'b1, 5'd14, 32'h104);
      tick(3'b001, "starve_md");
      drive_md(1'b0, 5'd0, 32'h0);
      tick(3'b100, "starve_pipe_back");
      drive_pipe(1'b0, 5'd0, 32'h0);
      tick(3'b000, "starve_idle");

      // load and mul/div starve together: load first, then mul/div, then pipe
      drive_ld(1'b1, 5'd20, 32'hA0A0_0001);
      drive_md(1'b1, 5'd21, 32'hB0B0_0002);
      for (int i = 0; i < 4; i++) begin
         drive_pipe(1'b1, 5'(24 + i), $urandom_range(0, 32'hFFFF));
         tick(3'b100, "dbl_pipe");
      end
      drive_pipe(1'b1, 5'd28, 32'h5555);
      tick(3'b010, "dbl_ld");
      drive_ld(1'b0, 5'd0, 32'h0);
      tick(3'b001, "dbl_md");
      drive_md(1'b0, 5'd0, 32'h0);
      tick(3'b100, "dbl_pipe_after");
      drive_pipe(1'b0, 5'd0, 32'h0);
      tick(3'b000, "dbl_idle");

      // rd==0 consumes the grant without writing
      drive_md(1'b1, 5'd0, 32'hFFFF);
      tick(3'b001, "rd0_md");
      drive_md(1'b0, 5'd0, 32'h0);
      drive_pipe(1'b1, 5'd9, 32'h9999);
      tick(3'b100, "rd0_pipe");
      drive_pipe(1'b0, 5'd0, 32'h0);
      tick(3'b000, "rd0_idle");

      // reset in the middle of pending requests; they are served afterwards
      drive_ld(1'b1, 5'd4, 32'h4444);
      drive_md(1'b1, 5'd6, 32'h6666);
      rst = 1'b1;
      tick(3'b000, "midrst");
      rst = 1'b0;
      tick(3'b010, "midrst_ld");
      drive_ld(1'b0, 5'd0, 32'h0);
      tick(3'b001, "midrst_md");
      drive_md(1'b0, 5'd0, 32'h0);
      tick(3'b000, "midrst_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among three result producers:
  - main pipe (ALU / PC+1 / U-imm results)
  - load response path
  - multi-cycle mul/div unit
- Sits between those producers and the commit/writeback stage.
- Valid/ready handshake on each requester; registered write port; fixed priority with per-requester starvation promotion.

Parameters:
- XLEN, 32, data width of every requester and of the write port.
- STARVE_LIMIT, 4, cycles a valid, ungranted load/mul-div request waits before promotion above the pipe (range 1..15).
- CNT_W, $clog2(STARVE_LIMIT+1), width of the wait counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_valid  in  1  main-pipe result available.
- pipe_rd  in  5  destination register.
- pipe_data  in  XLEN  result value.
- pipe_ready  out  1  pipe request accepted this cycle.
- ld_valid  in  1  load result available.
- ld_rd  in  5  destination register.
- ld_data  in  XLEN  load value.
- ld_ready  out  1  load request accepted this cycle.
- md_valid  in  1  mul/div result available.
- md_rd  in  5  destination register.
- md_data  in  XLEN  mul/div value.
- md_ready  out  1  mul/div request accepted this cycle.
- wb_we  out  1  register-file write enable.
- wb_rd  out  5  write address.
- wb_data  out  XLEN  write data.

Behaviour:
- Clock/reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - wb_we=0, wb_rd=0, wb_data=0.
  - Both wait counters = 0.
  - *_ready are combinational and depend only on current valids and counters.
- Handshake:
  - Transfer occurs when valid && ready.
  - A requester holds valid, rd and data stable until accepted.
  - At most one *_ready is high per cycle; ready is never high for a requester whose valid is low.
- Priority order, highest first:
  1. load if ld_cnt==STARVE_LIMIT
  2. mul/div if md_cnt==STARVE_LIMIT
  3. pipe
  4. load
  5. mul/div
- Wait counters (ld_cnt, md_cnt):
  - Cleared when the requester is granted or its valid is low.
  - Otherwise incremented each cycle, saturating at STARVE_LIMIT.
- Latency:
  - Granted rd/data appear on wb_rd/wb_data the next cycle.
  - wb_we=1 that cycle iff the granted rd!=0.
  - With no grant, the next cycle wb_we=0 and wb_rd/wb_data hold their previous values.
- rd==0: request is accepted normally (consumes a grant slot), but no write is issued (wb_we=0).
- Simultaneous valids: exactly one grant, per the priority order; losers keep valid, and their counters advance.
- Both counters starved in the same cycle: load wins; mul/div stays at STARVE_LIMIT and wins the next cycle unless the load requester is starved again.
- WAW ordering across requesters is guaranteed by issue-stage stalling (no two outstanding requests share a nonzero rd). The arbiter does no ordering checks.
- Reset mid-operation: in the reset cycle, no grant is issued (all ready=0), counters clear, and wb_we=0 next cycle. Requesters keep their valids and are served after reset.
- Throughput: one write per cycle maximum. The pipe is never starved by more than one cycle per promotion.

Decomposition:
- Shared package (wb_pkg) holds:
  - requester enum: REQ_PIPE, REQ_LD, REQ_MD, REQ_NONE.
  - a wb_req_t struct {valid, rd[4:0], data[XLEN-1:0]}.
  - constant XLEN.
- One natural sub-module: wb_starve_ctr, a saturating wait counter with starved flag, instantiated twice (load, mul/div).
- Grant logic and the output register stay in the top.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all valids=1 -> all ready=0 throughout; wb_we=0, wb_rd=0, wb_data=0 the cycle after rst falls.
- Single request: pipe_valid=1, pipe_rd=5, pipe_data=0x1234 for 1 cycle -> pipe_ready=1 that cycle; next cycle wb_we=1, wb_rd=5, wb_data=0x1234.
- Priority: pipe, ld and md all valid from t0 (rd 1/2/3) -> grants pipe@t0, ld@t1, md@t2; wb_rd shows 1,2,3 on t1..t3.
- Starvation: pipe_valid held 1 with a new rd each cycle, md_valid=1 (rd=7, data=0xBEEF) from t0, STARVE_LIMIT=4 -> pipe granted t0..t3; md_ready=1 at t4; wb_rd=7, wb_data=0xBEEF at t5; pipe granted again at t5.
- Double starvation: ld and md both valid and blocked by pipe until both counters reach 4 -> ld granted first, md the next cycle, pipe after.
- rd==0: md_valid=1, md_rd=0, md_data=0xFFFF -> md_ready=1; next cycle wb_we=0; a following pipe write to rd=9 lands with wb_we=1.
